// File: rtl/moore_seq_ctrl.sv
// Moore serial pattern detector controller: config latch, frame arm, history shift, match count.
// Optional MOORE_SEQ_NONOVERLAP_EN: clear history on each hit so matches never share bits.
module moore_seq_ctrl #(
  parameter int PAT_W      = 4,
  parameter int CNT_W      = 8,
  parameter int FRAME_BITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic             start,
  input  logic             stop,
  input  logic             din,
  input  logic             din_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);
  // state | meaning
  // IDLE  | accept config, wait for start; last match_cnt readable
  // RUN   | stream valid bits, detect and count matches
  // DONE  | one-cycle done pulse, then back to IDLE
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] hist, pattern, hist_next, len_mask;
  logic [LEN_W-1:0] len, fill, fill_next, len_clamped;
  logic [15:0]      bit_cnt, bit_cnt_next;
  logic             hit, frame_end;

  always_comb begin
    len_clamped = LEN_W'(cfg_len);
    if (cfg_len == 3'd0)
      len_clamped = LEN_W'(1);
    else if (int'(cfg_len) > PAT_W)
      len_clamped = LEN_W'(PAT_W);
  end

  always_comb begin
    hist_next    = {hist[PAT_W-2:0], din};
    fill_next    = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    bit_cnt_next = bit_cnt + 16'd1;
    frame_end    = (bit_cnt_next == 16'(FRAME_BITS));
    len_mask     = '0;
    for (int i = 0; i < PAT_W; i++)
      len_mask[i] = (LEN_W'(i) < len);
    hit = (fill_next >= len) && (((hist_next ^ pattern) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match     <= 1'b0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hist      <= '0;
      bit_cnt   <= '0;
      fill      <= '0;
      pattern   <= '0;
      len       <= LEN_W'(1);
    end else if (ena) begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          match <= 1'b0;
          if (cfg_we) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
          end
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            match_cnt <= '0;
            hist      <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
          end
        end
        RUN: begin
          if (din_valid) begin
            hist    <= hist_next;
            fill    <= fill_next;
            bit_cnt <= bit_cnt_next;
            match   <= hit;
            if (hit && (match_cnt != '1))
              match_cnt <= match_cnt + CNT_W'(1);
`ifdef MOORE_SEQ_NONOVERLAP_EN
            if (hit) begin
              hist <= '0;
              fill <= '0;
            end
`endif
          end else begin
            match <= 1'b0;
          end
          // the completing bit of the frame is still processed above
          if ((din_valid && frame_end) || stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          match <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Self-checking bench for moore_seq_ctrl: vector table plus frame-end, saturation and reset sequences.
module tb_moore_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_we, start, stop, din, din_valid;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       match, busy, done, match2, busy2, done2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int errors = 0;
  int checks = 0;

`ifdef MOORE_SEQ_NONOVERLAP_EN
  localparam bit NONOV = 1'b1;
`else
  localparam bit NONOV = 1'b0;
`endif

  always #5 clk = ~clk;

  moore_seq_ctrl #(.PAT_W(4), .CNT_W(8), .FRAME_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .start(start), .stop(stop), .din(din), .din_valid(din_valid),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done));

  moore_seq_ctrl #(.PAT_W(4), .CNT_W(2), .FRAME_BITS(32)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .start(start), .stop(stop), .din(din), .din_valid(din_valid),
    .match(match2), .match_cnt(match_cnt2), .busy(busy2), .done(done2));

  typedef struct {
    string      name;
    logic       ena;
    logic [3:0] ctl;   // {cfg_we, start, stop, din_valid}
    logic       din;
    logic [3:0] pat;
    logic [2:0] len;
    logic       em;
    int         ec;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(string n, logic [3:0] ctl, logic d, logic [3:0] pat,
                              logic [2:0] len, logic em, int ec, logic eb, logic ed,
                              logic en = 1'b1);
    vec_t v;
    v.name = n; v.ena = en; v.ctl = ctl; v.din = d; v.pat = pat; v.len = len;
    v.em = em; v.ec = ec; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    ena = v.ena;
    {cfg_we, start, stop, din_valid} = v.ctl;
    din = v.din; cfg_pattern = v.pat; cfg_len = v.len;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".match"}, 32'(match), 32'(e.em));
    chk({e.name, ".cnt"},   32'(match_cnt), 32'(e.ec));
    chk({e.name, ".busy"},  32'(busy), 32'(e.eb));
    chk({e.name, ".done"},  32'(done), 32'(e.ed));
    chk({e.name, ".cnt_sat"}, 32'(match_cnt2), (e.ec > 3) ? 32'd3 : 32'(e.ec));
  endtask

  int cb;

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_we = 0; start = 0; stop = 0; din = 0; din_valid = 0;
    cfg_pattern = '0; cfg_len = '0;
    #17;
    chk("reset.match", 32'(match), 0);
    chk("reset.cnt", 32'(match_cnt), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pattern 1011, len 4
    vecs.push_back(mk("a_arm",  4'b1100, 0, 4'b1011, 3'd4, 0, 0, 1, 0));
    vecs.push_back(mk("a_b1",   4'b0001, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("a_b2",   4'b0001, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("a_b3",   4'b0001, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("a_b4",   4'b0001, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("a_gap",  4'b0000, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk("a_stop", 4'b0010, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("a_idle", 4'b0000, 0, 0, 0, 0, 1, 0, 0));
    // pattern 11, len 2 on 1111, then cfg/start in RUN, then stop with completing bit
    cb = NONOV ? 2 : 3;
    vecs.push_back(mk("b_arm",  4'b1100, 0, 4'b0011, 3'd2, 0, 0, 1, 0));
    vecs.push_back(mk("b_b1",   4'b0001, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("b_b2",   4'b0001, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("b_b3",   4'b0001, 1, 0, 0, !NONOV, NONOV ? 1 : 2, 1, 0));
    vecs.push_back(mk("b_b4",   4'b0001, 1, 0, 0, 1, cb, 1, 0));
    vecs.push_back(mk("b_cfgrun", 4'b1101, 0, 4'b0000, 3'd1, 0, cb, 1, 0));
    vecs.push_back(mk("b_b6",   4'b0001, 1, 0, 0, 0, cb, 1, 0));
    vecs.push_back(mk("b_stophit", 4'b0011, 1, 0, 0, 1, cb + 1, 0, 1));
    vecs.push_back(mk("b_done_start", 4'b0100, 0, 0, 0, 0, cb + 1, 0, 0));
    vecs.push_back(mk("b_idle", 4'b0000, 0, 0, 0, 0, cb + 1, 0, 0));
    // cfg_len 0 clamps to 1; ena low freezes everything
    vecs.push_back(mk("c_arm",  4'b1100, 0, 4'b0001, 3'd0, 0, 0, 1, 0));
    vecs.push_back(mk("c_b1",   4'b0001, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("c_b0",   4'b0001, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk("c_b1b",  4'b0001, 1, 0, 0, 1, 2, 1, 0));
    vecs.push_back(mk("c_ena0a", 4'b0001, 1, 0, 0, 1, 2, 1, 0, 1'b0));
    vecs.push_back(mk("c_ena0b", 4'b0011, 1, 0, 0, 1, 2, 1, 0, 1'b0));
    vecs.push_back(mk("c_ena0c", 4'b0001, 1, 0, 0, 1, 2, 1, 0, 1'b0));
    vecs.push_back(mk("c_b0b",  4'b0001, 0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk("c_stop", 4'b0010, 0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk("c_idle", 4'b0000, 0, 0, 0, 0, 2, 0, 0));
    // cfg_len 7 clamps to 4
    vecs.push_back(mk("d_arm",  4'b1100, 0, 4'b1111, 3'd7, 0, 0, 1, 0));
    vecs.push_back(mk("d_b1",   4'b0001, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_b2",   4'b0001, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_b3",   4'b0001, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_b4",   4'b0001, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("d_stop", 4'b0010, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("d_idle", 4'b0000, 0, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // full frame: len 1 pattern 0 hits on every bit; 32nd bit ends the frame
    apply(mk("f_arm", 4'b1100, 0, 4'b0000, 3'd1, 0, 0, 1, 0));
    for (int k = 1; k <= 32; k++)
      apply(mk($sformatf("f_bit%0d", k), 4'b0001, 0, 0, 0, 1, k, k < 32, k == 32));
    apply(mk("f_after", 4'b0000, 0, 0, 0, 0, 32, 0, 0));
    apply(mk("f_idle",  4'b0000, 0, 0, 0, 0, 32, 0, 0));

    // reset mid-frame with count 3
    apply(mk("r_arm", 4'b1100, 0, 4'b0001, 3'd1, 0, 0, 1, 0));
    apply(mk("r_b1",  4'b0001, 1, 0, 0, 1, 1, 1, 0));
    apply(mk("r_b2",  4'b0001, 1, 0, 0, 1, 2, 1, 0));
    apply(mk("r_b3",  4'b0001, 1, 0, 0, 1, 3, 1, 0));
    rst_n = 1'b0;
    #1;
    chk("rmid.match", 32'(match), 0);
    chk("rmid.cnt", 32'(match_cnt), 0);
    chk("rmid.busy", 32'(busy), 0);
    chk("rmid.done", 32'(done), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk("r_idle1", 4'b0001, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("r_idle2", 4'b0000, 0, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
